// File: rtl/video_pkg.sv
// Shared constants and helpers for the video output stage: BT.601 matrix
// coefficients, limited-range bounds, full-range gain and scanline modes.
package video_pkg;

    localparam int signed Y_KR  = 66;
    localparam int signed Y_KG  = 129;
    localparam int signed Y_KB  = 25;
    localparam int signed PB_KR = -38;
    localparam int signed PB_KG = -74;
    localparam int signed PB_KB = 112;
    localparam int signed PR_KR = 112;
    localparam int signed PR_KG = -94;
    localparam int signed PR_KB = -18;

    localparam int signed ROUND_HALF = 128;
    localparam int signed Y_OFFSET   = 16;
    localparam int signed C_OFFSET   = 128;

    localparam int signed LIM_LO     = 16;
    localparam int signed LIM_Y_HI   = 235;
    localparam int signed LIM_C_HI   = 240;
    localparam int signed FULL_GAIN  = 298;

    typedef enum logic [1:0] {
        SL_NONE = 2'b00,
        SL_25   = 2'b01,
        SL_50   = 2'b10,
        SL_75   = 2'b11
    } scanline_e;

    // Darken one 8-bit component by the selected scanline strength.
    function automatic logic [7:0] scanline_dim(input logic [7:0] x, input scanline_e mode);
        logic [7:0] y;
        y = x;
        case (mode)
            SL_25:   y = (x >> 1) + (x >> 2);
            SL_50:   y = x >> 1;
            SL_75:   y = x >> 2;
            default: y = x;
        endcase
        return y;
    endfunction

    // One row of the matrix: offset + (kr*R + kg*G + kb*B + 128) >>> 8.
    function automatic logic signed [9:0] bt601_mac(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input int signed  kr,
        input int signed  kg,
        input int signed  kb,
        input int signed  offset
    );
        int signed acc;
        acc = kr * int'(r) + kg * int'(g) + kb * int'(b) + ROUND_HALF;
        acc = acc >>> 8;
        return 10'(acc + offset);
    endfunction

    // Clamp to the limited range, then optionally expand to 0..255 with saturation.
    function automatic logic [7:0] range_map(
        input logic signed [9:0] v,
        input int signed         hi,
        input logic              full
    );
        int signed c;
        int signed f;
        c = int'(v);
        if (c < LIM_LO) begin
            c = LIM_LO;
        end else if (c > hi) begin
            c = hi;
        end
        f = c;
        if (full) begin
            f = ((c - LIM_LO) * FULL_GAIN + ROUND_HALF) >>> 8;
            if (f > 255) begin
                f = 255;
            end else if (f < 0) begin
                f = 0;
            end
        end
        return 8'(f);
    endfunction

endpackage

// File: rtl/video_rgb2ypbpr.sv
// BT.601 RGB -> YPbPr conversion: matrix stage followed by range-map stage,
// two register stages in total.
module video_rgb2ypbpr
    import video_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    input  logic       full_i,
    output logic [7:0] y_o,
    output logic [7:0] pb_o,
    output logic [7:0] pr_o
);

    logic signed [9:0] y_s2_d,  y_s2_q;
    logic signed [9:0] pb_s2_d, pb_s2_q;
    logic signed [9:0] pr_s2_d, pr_s2_q;
    logic              full_s2_q;
    logic [7:0]        y_s3_d,  y_s3_q;
    logic [7:0]        pb_s3_d, pb_s3_q;
    logic [7:0]        pr_s3_d, pr_s3_q;

    // Matrix products with rounding, offsets added.
    always_comb begin
        y_s2_d  = bt601_mac(r_i, g_i, b_i, Y_KR,  Y_KG,  Y_KB,  Y_OFFSET);
        pb_s2_d = bt601_mac(r_i, g_i, b_i, PB_KR, PB_KG, PB_KB, C_OFFSET);
        pr_s2_d = bt601_mac(r_i, g_i, b_i, PR_KR, PR_KG, PR_KB, C_OFFSET);
    end

    // Clamp to limited range and optional full-range expansion.
    always_comb begin
        y_s3_d  = range_map(y_s2_q,  LIM_Y_HI, full_s2_q);
        pb_s3_d = range_map(pb_s2_q, LIM_C_HI, full_s2_q);
        pr_s3_d = range_map(pr_s2_q, LIM_C_HI, full_s2_q);
    end

    // Stage registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            y_s2_q    <= '0;
            pb_s2_q   <= '0;
            pr_s2_q   <= '0;
            full_s2_q <= 1'b0;
            y_s3_q    <= '0;
            pb_s3_q   <= '0;
            pr_s3_q   <= '0;
        end else begin
            y_s2_q    <= y_s2_d;
            pb_s2_q   <= pb_s2_d;
            pr_s2_q   <= pr_s2_d;
            full_s2_q <= full_i;
            y_s3_q    <= y_s3_d;
            pb_s3_q   <= pb_s3_d;
            pr_s3_q   <= pr_s3_d;
        end
    end

    assign y_o  = y_s3_q;
    assign pb_o = pb_s3_q;
    assign pr_o = pr_s3_q;

endmodule

// File: rtl/video_ypbpr_pipe.sv
// Pipelined video output stage: blanking, scanline darkening, RGB or
// BT.601 YPbPr output, and delayed active-low syncs. Latency 3 cycles.
module video_ypbpr_pipe
    import video_pkg::*;
#(
    parameter int COLOR_W = 6,
    parameter int OUT_W   = 6
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               blank_in,
    input  logic [1:0]         scanlines,
    input  logic               csync_en,
    input  logic               ypbpr,
    input  logic               ypbpr_full,
    output logic [OUT_W-1:0]   r_out,
    output logic [OUT_W-1:0]   g_out,
    output logic [OUT_W-1:0]   b_out,
    output logic               hs_out,
    output logic               vs_out
);

    scanline_e  sl_mode;
    logic       hs_prev_q, vs_prev_q;
    logic       parity_d, parity_q;

    logic [7:0] r_s1_d, g_s1_d, b_s1_d;
    logic [7:0] r_s1_q, g_s1_q, b_s1_q;
    logic       hs_s1_q, vs_s1_q, comp_s1_q, ypbpr_s1_q, full_s1_q;

    logic [7:0] r_s2_q, g_s2_q, b_s2_q;
    logic       hs_s2_q, vs_s2_q, comp_s2_q, ypbpr_s2_q;

    logic [7:0] r_s3_q, g_s3_q, b_s3_q;
    logic       ypbpr_s3_q;
    logic       hs_out_d, vs_out_d, hs_out_q, vs_out_q;

    logic [7:0] y_s3, pb_s3, pr_s3;

    assign sl_mode = scanline_e'(scanlines);

    // Line parity: toggles on hs falling edge, vs falling edge wins and clears.
    always_comb begin
        parity_d = parity_q;
        if (vs_prev_q && !vs_in) begin
            parity_d = 1'b0;
        end else if (hs_prev_q && !hs_in) begin
            parity_d = ~parity_q;
        end
    end

    // S1 pixel: MSB-replicate to 8 bits, blank, then darken odd lines.
    always_comb begin
        r_s1_d = 8'({r_in, r_in} >> (2 * COLOR_W - 8));
        g_s1_d = 8'({g_in, g_in} >> (2 * COLOR_W - 8));
        b_s1_d = 8'({b_in, b_in} >> (2 * COLOR_W - 8));
        if (blank_in) begin
            r_s1_d = '0;
            g_s1_d = '0;
            b_s1_d = '0;
        end
        if (parity_q) begin
            r_s1_d = scanline_dim(r_s1_d, sl_mode);
            g_s1_d = scanline_dim(g_s1_d, sl_mode);
            b_s1_d = scanline_dim(b_s1_d, sl_mode);
        end
    end

    // Active-low sync generation from the S2-delayed sync and mode bits.
    always_comb begin
        hs_out_d = comp_s2_q ? ~(hs_s2_q ^ vs_s2_q) : ~hs_s2_q;
        vs_out_d = comp_s2_q ? 1'b1 : ~vs_s2_q;
    end

    // Parity tracker, S1/S2/S3 pixel, sync and mode delay line.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            parity_q   <= 1'b0;
            r_s1_q     <= '0;
            g_s1_q     <= '0;
            b_s1_q     <= '0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            comp_s1_q  <= 1'b0;
            ypbpr_s1_q <= 1'b0;
            full_s1_q  <= 1'b0;
            r_s2_q     <= '0;
            g_s2_q     <= '0;
            b_s2_q     <= '0;
            hs_s2_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            comp_s2_q  <= 1'b0;
            ypbpr_s2_q <= 1'b0;
            r_s3_q     <= '0;
            g_s3_q     <= '0;
            b_s3_q     <= '0;
            ypbpr_s3_q <= 1'b0;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
        end else begin
            hs_prev_q  <= hs_in;
            vs_prev_q  <= vs_in;
            parity_q   <= parity_d;
            r_s1_q     <= r_s1_d;
            g_s1_q     <= g_s1_d;
            b_s1_q     <= b_s1_d;
            hs_s1_q    <= hs_in;
            vs_s1_q    <= vs_in;
            comp_s1_q  <= ypbpr | csync_en;
            ypbpr_s1_q <= ypbpr;
            full_s1_q  <= ypbpr_full;
            r_s2_q     <= r_s1_q;
            g_s2_q     <= g_s1_q;
            b_s2_q     <= b_s1_q;
            hs_s2_q    <= hs_s1_q;
            vs_s2_q    <= vs_s1_q;
            comp_s2_q  <= comp_s1_q;
            ypbpr_s2_q <= ypbpr_s1_q;
            r_s3_q     <= r_s2_q;
            g_s3_q     <= g_s2_q;
            b_s3_q     <= b_s2_q;
            ypbpr_s3_q <= ypbpr_s2_q;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
        end
    end

    video_rgb2ypbpr u_matrix (
        .clk_i   (clk_sys),
        .rst_n_i (reset_n),
        .r_i     (r_s1_q),
        .g_i     (g_s1_q),
        .b_i     (b_s1_q),
        .full_i  (full_s1_q),
        .y_o     (y_s3),
        .pb_o    (pb_s3),
        .pr_o    (pr_s3)
    );

    // Output select between registered RGB and YPbPr; the select travels
    // with the pixel so a mode change never splits a pixel.
    always_comb begin
        r_out = ypbpr_s3_q ? OUT_W'(pr_s3 >> (8 - OUT_W)) : OUT_W'(r_s3_q >> (8 - OUT_W));
        g_out = ypbpr_s3_q ? OUT_W'(y_s3  >> (8 - OUT_W)) : OUT_W'(g_s3_q >> (8 - OUT_W));
        b_out = ypbpr_s3_q ? OUT_W'(pb_s3 >> (8 - OUT_W)) : OUT_W'(b_s3_q >> (8 - OUT_W));
        hs_out = hs_out_q;
        vs_out = vs_out_q;
    end

endmodule

// File: tb/tb_video_ypbpr_pipe.sv
// Scoreboard bench for video_ypbpr_pipe: a driver pushes expected outputs
// from an arithmetic reference model, a monitor pops them 3 cycles later.
module tb_video_ypbpr_pipe;

    localparam int CW = 6;
    localparam int OW = 6;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [CW-1:0] r_in, g_in, b_in;
    logic          hs_in, vs_in, blank_in;
    logic [1:0]    scanlines;
    logic          csync_en, ypbpr, ypbpr_full;
    logic [OW-1:0] r_out, g_out, b_out;
    logic          hs_out, vs_out;

    video_ypbpr_pipe #(.COLOR_W(CW), .OUT_W(OW)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .blank_in   (blank_in),
        .scanlines  (scanlines),
        .csync_en   (csync_en),
        .ypbpr      (ypbpr),
        .ypbpr_full (ypbpr_full),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [OW-1:0] r;
        logic [OW-1:0] g;
        logic [OW-1:0] b;
        logic          hs;
        logic          vs;
    } out_t;

    typedef struct {
        int unsigned due;
        out_t        exp;
        logic [63:0] tag;
    } sb_t;

    sb_t         sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    // Reference model state
    int m_par     = 0;
    bit m_hs_prev = 0;
    bit m_vs_prev = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic out_t mk(input int r, input int g, input int b, input bit hs, input bit vs);
        out_t o;
        o.r = OW'(r);
        o.g = OW'(g);
        o.b = OW'(b);
        o.hs = hs;
        o.vs = vs;
        return o;
    endfunction

    function automatic int fdiv256(input int v);
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int expand(input int c);
        return (c << (8 - CW)) | (c >> (2 * CW - 8));
    endfunction

    function automatic int darken(input int w, input int sl);
        case (sl)
            1: return w / 2 + w / 4;
            2: return w / 2;
            3: return w / 4;
            default: return w;
        endcase
    endfunction

    function automatic int to_full(input int v);
        return clampi(fdiv256((v - 16) * 298 + 128), 0, 255);
    endfunction

    // Drive one pixel for the next edge and queue its expected output.
    task automatic step(input bit rst_n, input int r, input int g, input int b,
                        input bit hs, input bit vs, input bit blank, input int sl,
                        input bit cs, input bit yp, input bit full,
                        input bit use_c, input out_t cexp, input logic [63:0] tag);
        out_t e;
        int   rr, gg, bb, y, pb, pr;
        bit   comp;
        @(posedge clk_sys);
        #1;
        reset_n    = rst_n;
        r_in       = CW'(r);
        g_in       = CW'(g);
        b_in       = CW'(b);
        hs_in      = hs;
        vs_in      = vs;
        blank_in   = blank;
        scanlines  = 2'(sl);
        csync_en   = cs;
        ypbpr      = yp;
        ypbpr_full = full;
        if (!rst_n) begin
            foreach (sbq[i]) if (sbq[i].due > cyc) sbq[i].exp = mk(0, 0, 0, 1, 1);
            e = mk(0, 0, 0, 1, 1);
            m_par = 0;
            m_hs_prev = 0;
            m_vs_prev = 0;
        end else begin
            rr = blank ? 0 : expand(r);
            gg = blank ? 0 : expand(g);
            bb = blank ? 0 : expand(b);
            if (m_par != 0) begin
                rr = darken(rr, sl);
                gg = darken(gg, sl);
                bb = darken(bb, sl);
            end
            y  = clampi(16  + fdiv256(66 * rr + 129 * gg + 25 * bb + 128), 16, 235);
            pb = clampi(128 + fdiv256(-38 * rr - 74 * gg + 112 * bb + 128), 16, 240);
            pr = clampi(128 + fdiv256(112 * rr - 94 * gg - 18 * bb + 128), 16, 240);
            if (full) begin
                y  = to_full(y);
                pb = to_full(pb);
                pr = to_full(pr);
            end
            comp = yp | cs;
            if (yp)
                e = mk(pr >> (8 - OW), y >> (8 - OW), pb >> (8 - OW), 0, 0);
            else
                e = mk(rr >> (8 - OW), gg >> (8 - OW), bb >> (8 - OW), 0, 0);
            e.hs = comp ? !(hs ^ vs) : !hs;
            e.vs = comp ? 1'b1 : !vs;
            if (m_vs_prev && !vs) m_par = 0;
            else if (m_hs_prev && !hs) m_par = 1 - m_par;
            m_hs_prev = hs;
            m_vs_prev = vs;
            if (use_c) e = cexp;
        end
        sbq.push_back('{due: cyc + 3, exp: e, tag: tag});
    endtask

    // Monitor: compare the DUT output against the entry due this cycle.
    always @(negedge clk_sys) begin
        sb_t  s;
        out_t act;
        if (sbq.size() > 0) begin
            if (sbq[0].due == cyc) begin
                s = sbq.pop_front();
                act = {r_out, g_out, b_out, hs_out, vs_out};
                checks++;
                if (act !== s.exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got r=%0d g=%0d b=%0d hs=%b vs=%b want r=%0d g=%0d b=%0d hs=%b vs=%b",
                             s.tag, cyc, act.r, act.g, act.b, act.hs, act.vs,
                             s.exp.r, s.exp.g, s.exp.b, s.exp.hs, s.exp.vs);
                end
            end else if (sbq[0].due < cyc) begin
                s = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL %s missed due=%0d now=%0d", s.tag, s.due, cyc);
            end
        end
    end

    initial begin
        out_t z;
        int   wait_cnt;
        bit   yp;
        z = mk(0, 0, 0, 1, 1);
        reset_n = 0; r_in = '0; g_in = '0; b_in = '0; hs_in = 0; vs_in = 0;
        blank_in = 0; scanlines = 2'b00; csync_en = 0; ypbpr = 0; ypbpr_full = 0;

        // Reset held with active inputs
        repeat (4) step(0, 63, 63, 63, 1, 0, 0, 0, 0, 1, 0, 0, z, "reset");

        // White and black through YPbPr, limited and full range
        repeat (4) step(1, 63, 63, 63, 0, 0, 0, 0, 0, 1, 0, 1, mk(32, 58, 32, 1, 1), "white_l");
        repeat (4) step(1, 63, 63, 63, 0, 0, 0, 0, 0, 1, 1, 1, mk(32, 63, 32, 1, 1), "white_f");
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, mk(32, 4, 32, 1, 1), "black_l");
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, mk(32, 0, 32, 1, 1), "black_f");

        // Scanline darkening on odd lines, RGB mode
        repeat (3) step(1, 40, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, mk(40, 0, 0, 1, 1), "sl_even");
        step(1, 40, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, z, "sl_hs");
        step(1, 40, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, z, "sl_fall");
        repeat (3) step(1, 40, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, mk(20, 0, 0, 1, 1), "sl_odd");
        step(1, 40, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0, z, "sl_hsvs");
        step(1, 40, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, z, "sl_both");
        repeat (3) step(1, 40, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, mk(40, 0, 0, 1, 1), "sl_clr");

        // Separate and composite syncs
        for (int i = 0; i < 8; i++)
            step(1, 5, 9, 13, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0, 0, 0, z, "sync_sep");
        for (int i = 0; i < 8; i++)
            step(1, 5, 9, 13, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 1, 0, 0, 0, z, "sync_cmp");

        // Mode toggled on every pixel boundary
        yp = 1;
        for (int i = 0; i < 8; i++) begin
            if (yp) step(1, 63, 63, 63, 0, 0, 0, 0, 0, 1, 0, 1, mk(32, 58, 32, 1, 1), "toggle");
            else    step(1, 63, 63, 63, 0, 0, 0, 0, 0, 0, 0, 1, mk(63, 63, 63, 1, 1), "toggle");
            yp = !yp;
        end

        // Randomised traffic including occasional mid-frame reset
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 0, z, "random");

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk_sys);
            wait_cnt++;
        end
        @(posedge clk_sys);
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
